cnn_grid_sequencer: RTL and testbench

Sequences one shared cell datapath (3x3 feedback/control template MAC plus output saturation) across a 2^RW x 2^CW cellular-neural-network grid, for a programmed number of Euler iterations. Per cell it gathers the 3x3 neighbourhood of state Y and input U from external synchronous RAMs and presents it with the template registers A, B and I. It captures the datapath result and writes it into the alternate bank of a ping-pong state memory. It sits between the host configuration/start logic and the combinational cell datapath.

---
 rtl/cnn_grid_sequencer_if.sv | 46 ++++
 rtl/cnn_grid_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cnn_grid_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_grid_sequencer_if.sv
// Bus bundle between the CNN grid sequencer and its host, Y/U RAMs and cell datapath.
// The sequencer uses the slave modport; the bench or top-level glue uses master.
interface cnn_grid_sequencer_if #(
  parameter int RW = 3,
  parameter int CW = 3
);
  // Handshake: start is a one-cycle request, taken only while busy is low.
  // busy rises the next cycle and holds through the one-cycle done pulse.
  // mem_rd_en qualifies both read addresses, and the data returns one cycle later.
  // y_we qualifies y_wr_addr/y_wr_data in the same cycle.
  logic                 cfg_we;
  logic [4:0]           cfg_addr;
  logic [7:0]           cfg_data;
  logic                 start;
  logic [7:0]           iter_count;
  logic                 busy;
  logic                 done;
  logic                 final_bank;
  logic                 mem_rd_en;
  logic [RW+CW:0]       y_rd_addr;
  logic [RW+CW-1:0]     u_rd_addr;
  logic [8:0]           y_rd_data;
  logic [7:0]           u_rd_data;
  logic                 y_we;
  logic [RW+CW:0]       y_wr_addr;
  logic [8:0]           y_wr_data;
  logic [71:0]          dp_a;
  logic [71:0]          dp_b;
  logic [71:0]          dp_u;
  logic [80:0]          dp_y;
  logic [7:0]           dp_i;
  logic [8:0]           dp_out;
  logic [2:0]           dbg_state;

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, iter_count, y_rd_data, u_rd_data, dp_out,
    output busy, done, final_bank, mem_rd_en, y_rd_addr, u_rd_addr, y_we, y_wr_addr,
           y_wr_data, dp_a, dp_b, dp_u, dp_y, dp_i, dbg_state
  );

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, iter_count, y_rd_data, u_rd_data, dp_out,
    input  busy, done, final_bank, mem_rd_en, y_rd_addr, u_rd_addr, y_we, y_wr_addr,
           y_wr_data, dp_a, dp_b, dp_u, dp_y, dp_i, dbg_state
  );
endinterface

// File: rtl/cnn_grid_sequencer.sv
// Walks one shared 3x3 cell datapath over a 2^RW x 2^CW CNN grid for N Euler iterations.
// It gathers the neighbourhood from the Y/U RAMs and writes each result into the other state bank.
module cnn_grid_sequencer #(
  parameter int RW = 3,
  parameter int CW = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  cnn_grid_sequencer_if.slave bus
);
  localparam int ROWS = 1 << RW;
  localparam int COLS = 1 << CW;
  localparam int AW   = RW + CW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_EVAL  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          r_state;
  logic [3:0]      r_tap;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [7:0]      r_iter;
  logic [7:0]      r_iter_cnt;
  logic            r_rd_bank;
  logic            r_final_bank;
  logic            r_busy;
  logic            r_done;
  logic            r_rd_en;
  logic            r_prev_en;
  logic [AW:0]     r_y_rd_addr;
  logic [AW-1:0]   r_u_rd_addr;
  logic            r_y_we;
  logic [AW:0]     r_y_wr_addr;
  logic [8:0]      r_y_wr_data;
  logic [7:0]      r_a [9];
  logic [7:0]      r_b [9];
  logic [7:0]      r_i;
  logic [8:0]      r_cap_y [9];
  logic [7:0]      r_cap_u [9];

  logic [CW-1:0]   w_nxt_col;
  logic [RW-1:0]   w_nxt_row;
  logic            w_last_cell;
  logic [7:0]      w_iter_nxt;
  logic            w_run_end;
  logic            w_iss;
  logic [RW-1:0]   w_iss_row;
  logic [CW-1:0]   w_iss_col;
  logic [3:0]      w_iss_tap;
  logic            w_iss_bank;
  logic            w_rd_go;
  logic [AW-1:0]   w_rd_cell;
  logic            w_cap;
  logic [3:0]      w_cap_slot;
  logic            w_cfg_ok;
  logic [71:0]     w_dp_a;
  logic [71:0]     w_dp_b;
  logic [71:0]     w_dp_u;
  logic [80:0]     w_dp_y;

  // Tap k sits at offset (k/3 - 1, k%3 - 1). Taps outside the grid read as zero.
  function automatic logic tap_in_grid(input logic [RW-1:0] row, input logic [CW-1:0] col,
                                       input logic [3:0] tap);
    int nr;
    int nc;
    nr = int'(row) + int'(tap) / 3 - 1;
    nc = int'(col) + int'(tap) % 3 - 1;
    return (nr >= 0) && (nr < ROWS) && (nc >= 0) && (nc < COLS);
  endfunction

  function automatic logic [AW-1:0] tap_cell(input logic [RW-1:0] row, input logic [CW-1:0] col,
                                             input logic [3:0] tap);
    int nr;
    int nc;
    nr = int'(row) + int'(tap) / 3 - 1;
    nc = int'(col) + int'(tap) % 3 - 1;
    return {RW'(nr), CW'(nc)};
  endfunction

  // Work out which tap is addressed next cycle, so the read strobe and addresses can be registered.
  always_comb begin
    w_nxt_col   = r_col + 1'b1;
    w_nxt_row   = (r_col == '1) ? r_row + 1'b1 : r_row;
    w_last_cell = (r_row == '1) && (r_col == '1);
    w_iter_nxt  = r_iter + 8'd1;
    w_run_end   = w_last_cell && (w_iter_nxt == r_iter_cnt);
    w_iss       = 1'b0;
    w_iss_row   = r_row;
    w_iss_col   = r_col;
    w_iss_tap   = 4'd0;
    w_iss_bank  = r_rd_bank;
    case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.iter_count != 8'd0)) begin
          w_iss      = 1'b1;
          w_iss_row  = '0;
          w_iss_col  = '0;
          w_iss_bank = 1'b0;
        end
      end
      S_FETCH: begin
        if (r_tap != 4'd8) begin
          w_iss     = 1'b1;
          w_iss_tap = r_tap + 4'd1;
        end
      end
      S_WRITE: begin
        if (!w_run_end) begin
          w_iss      = 1'b1;
          w_iss_row  = w_nxt_row;
          w_iss_col  = w_nxt_col;
          w_iss_bank = r_rd_bank ^ w_last_cell;
        end
      end
      default: ;
    endcase
    w_rd_go    = w_iss && tap_in_grid(w_iss_row, w_iss_col, w_iss_tap);
    w_rd_cell  = tap_cell(w_iss_row, w_iss_col, w_iss_tap);
    w_cap      = ((r_state == S_FETCH) && (r_tap != 4'd0)) || (r_state == S_DRAIN);
    w_cap_slot = r_tap - 4'd1;
    w_cfg_ok   = bus.cfg_we && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  always_comb begin
    w_dp_a = '0;
    w_dp_b = '0;
    w_dp_u = '0;
    w_dp_y = '0;
    for (int k = 0; k < 9; k++) begin
      w_dp_a[8*k +: 8] = r_a[k];
      w_dp_b[8*k +: 8] = r_b[k];
      w_dp_u[8*k +: 8] = r_cap_u[k];
      w_dp_y[9*k +: 9] = r_cap_y[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tap        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_iter       <= '0;
      r_iter_cnt   <= '0;
      r_rd_bank    <= 1'b0;
      r_final_bank <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rd_en      <= 1'b0;
      r_prev_en    <= 1'b0;
      r_y_rd_addr  <= '0;
      r_u_rd_addr  <= '0;
      r_y_we       <= 1'b0;
      r_y_wr_addr  <= '0;
      r_y_wr_data  <= '0;
      r_i          <= '0;
      for (int k = 0; k < 9; k++) begin
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_cap_y[k] <= '0;
        r_cap_u[k] <= '0;
      end
    end else begin
      r_prev_en <= r_rd_en;
      r_rd_en   <= w_rd_go;
      if (w_rd_go) begin
        r_y_rd_addr <= {w_iss_bank, w_rd_cell};
        r_u_rd_addr <= w_rd_cell;
      end
      // Read data always belongs to the tap addressed one cycle earlier.
      if (w_cap) begin
        r_cap_y[w_cap_slot] <= r_prev_en ? bus.y_rd_data : 9'd0;
        r_cap_u[w_cap_slot] <= r_prev_en ? bus.u_rd_data : 8'd0;
      end
      if (w_cfg_ok) begin
        if (bus.cfg_addr < 5'd9)
          r_a[bus.cfg_addr[3:0]] <= bus.cfg_data;
        else if (bus.cfg_addr < 5'd18)
          r_b[4'(bus.cfg_addr - 5'd9)] <= bus.cfg_data;
        else if (bus.cfg_addr == 5'd18)
          r_i <= bus.cfg_data;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_iter_cnt <= bus.iter_count;
            r_rd_bank  <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_iter     <= '0;
            r_tap      <= '0;
            r_busy     <= 1'b1;
            if (bus.iter_count == 8'd0) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_final_bank <= 1'b0;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          r_tap <= r_tap + 4'd1;
          if (r_tap == 4'd8) r_state <= S_DRAIN;
        end
        S_DRAIN: r_state <= S_EVAL;
        S_EVAL: begin
          r_y_wr_data <= bus.dp_out;
          r_y_wr_addr <= {~r_rd_bank, r_row, r_col};
          r_y_we      <= 1'b1;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          r_y_we <= 1'b0;
          r_col  <= w_nxt_col;
          r_row  <= w_nxt_row;
          r_tap  <= '0;
          if (w_last_cell) begin
            r_rd_bank <= ~r_rd_bank;
            r_iter    <= w_iter_nxt;
          end
          if (w_run_end) begin
            r_state      <= S_DONE;
            r_done       <= 1'b1;
            r_final_bank <= ~r_rd_bank;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.final_bank = r_final_bank;
  assign bus.mem_rd_en  = r_rd_en;
  assign bus.y_rd_addr  = r_y_rd_addr;
  assign bus.u_rd_addr  = r_u_rd_addr;
  assign bus.y_we       = r_y_we;
  assign bus.y_wr_addr  = r_y_wr_addr;
  assign bus.y_wr_data  = r_y_wr_data;
  assign bus.dp_a       = w_dp_a;
  assign bus.dp_b       = w_dp_b;
  assign bus.dp_u       = w_dp_u;
  assign bus.dp_y       = w_dp_y;
  assign bus.dp_i       = r_i;
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_cnn_grid_sequencer.sv
// Directed bench for cnn_grid_sequencer on an 8x8 grid with behavioural Y/U RAMs and a saturating MAC datapath.
module tb_cnn_grid_sequencer;
  localparam int RW = 3;
  localparam int CW = 3;
  localparam int NC = 64;
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cnn_grid_sequencer_if #(.RW(RW), .CW(CW)) bus();
  cnn_grid_sequencer #(.RW(RW), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Synchronous RAMs. U is read-only, and Y is written by the sequencer or preloaded by tasks.
  logic [8:0] y_mem [0:127];
  logic [7:0] u_mem [0:63];
  logic [8:0] y_q = '0;
  logic [7:0] u_q = '0;
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      y_q <= y_mem[bus.y_rd_addr];
      u_q <= u_mem[bus.u_rd_addr];
    end
    if (bus.y_we) y_mem[bus.y_wr_addr] = bus.y_wr_data;
  end
  assign bus.y_rd_data = y_q;
  assign bus.u_rd_data = u_q;

  int dp_acc;
  always_comb begin
    dp_acc = int'($signed(bus.dp_i));
    for (int k = 0; k < 9; k++)
      dp_acc = dp_acc + int'($signed(bus.dp_a[8*k +: 8])) * int'($signed(bus.dp_y[9*k +: 9]))
                      + int'($signed(bus.dp_b[8*k +: 8])) * int'($signed(bus.dp_u[8*k +: 8]));
    if (dp_acc > 255) bus.dp_out = 9'h0ff;
    else if (dp_acc < -256) bus.dp_out = 9'h100;
    else bus.dp_out = 9'(dp_acc);
  end

  logic [15:0] wr_log [$];
  logic [6:0]  rd_log [$];
  always @(negedge clk) begin
    if (bus.mem_rd_en) rd_log.push_back(bus.y_rd_addr);
    if (bus.y_we) wr_log.push_back({bus.y_wr_addr, bus.y_wr_data});
  end

  logic [15:0] exp_q [$];
  logic [8:0]  en0, en63;
  logic [80:0] snap_y0, snap_y63;
  logic [71:0] snap_u0;
  logic        busy_at_done, busy_after, final_at_done;
  int          lat;

  int ta [9] = '{1, -2, 3, -1, 2, 1, -3, 2, 1};
  int tb [9] = '{2, 1, -1, 0, 3, -2, 1, 1, -1};
  int ti = 5;
  int y_init [64];
  int u_init [64];

  task automatic cfg_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic fill_y(input int v);
    for (int i = 0; i < NC; i++) y_mem[i] = 9'(v);
  endtask

  // Cycle 1 is the cycle after the start cycle. lat is the cycle index of done, or -1 on timeout.
  task automatic run(input logic [7:0] n, input bit poke, output int l);
    int cyc;
    @(negedge clk);
    rd_log.delete(); wr_log.delete();
    bus.start = 1'b1; bus.iter_count = n;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1; l = -1;
    while (cyc < LIMIT) begin
      if (cyc <= 9) en0[cyc-1] = bus.mem_rd_en;
      if (cyc >= 757 && cyc <= 765) en63[cyc-757] = bus.mem_rd_en;
      if (cyc == 11) begin snap_y0 = bus.dp_y; snap_u0 = bus.dp_u; end
      if (cyc == 767) snap_y63 = bus.dp_y;
      if (poke && cyc == 50) begin
        bus.start = 1'b1; bus.cfg_we = 1'b1; bus.cfg_addr = 5'd4; bus.cfg_data = 8'h55;
      end else begin
        bus.start = 1'b0; bus.cfg_we = 1'b0;
      end
      if (bus.done) begin
        l = cyc; busy_at_done = bus.busy; final_at_done = bus.final_bank;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    busy_after = bus.busy;
  endtask

  function automatic int ref_cell(input int r, input int c);
    int acc;
    int nr;
    int nc;
    acc = ti;
    for (int k = 0; k < 9; k++) begin
      nr = r + k / 3 - 1;
      nc = c + k % 3 - 1;
      if (nr >= 0 && nr < 8 && nc >= 0 && nc < 8)
        acc += ta[k] * y_init[nr*8+nc] + tb[k] * u_init[nr*8+nc];
    end
    if (acc > 255) acc = 255;
    if (acc < -256) acc = -256;
    return acc;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.mem_rd_en, bus.y_we, bus.final_bank} !== 5'b0) begin
      n_errors++; $display("FAIL reset_flags got %b want 00000", {bus.busy, bus.done, bus.mem_rd_en, bus.y_we, bus.final_bank});
    end
    n_checks++;
    if ({bus.dp_a, bus.dp_b, bus.dp_i} !== '0 || bus.dp_y !== '0 || bus.dp_u !== '0) begin
      n_errors++; $display("FAIL reset_dp got a=%h y=%h want 0", bus.dp_a, bus.dp_y);
    end
    n_checks++;
    if (bus.dbg_state !== 3'd0 || bus.y_rd_addr !== '0 || bus.y_wr_addr !== '0) begin
      n_errors++; $display("FAIL reset_state got st=%0d ra=%h wa=%h want 0", bus.dbg_state, bus.y_rd_addr, bus.y_wr_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_iter();
    logic [71:0] ea;
    ea = '0; ea[39:32] = 8'd2;
    cfg_write(5'd4, 8'd2);
    n_checks++;
    if (bus.dp_a !== ea) begin n_errors++; $display("FAIL single_dp_a got %h want %h", bus.dp_a, ea); end
    fill_y(3);
    run(8'd1, 1'b0, lat);
    n_checks++;
    if (lat !== 769) begin n_errors++; $display("FAIL single_latency got %0d want 769", lat); end
    n_checks++;
    if ({busy_at_done, busy_after, final_at_done} !== 3'b101) begin
      n_errors++; $display("FAIL single_busy_final got %b want 101", {busy_at_done, busy_after, final_at_done});
    end
    n_checks++;
    if (rd_log.size() !== 484) begin n_errors++; $display("FAIL single_reads got %0d want 484", rd_log.size()); end
    exp_q.delete();
    for (int i = 0; i < NC; i++) exp_q.push_back({1'b1, 6'(i), 9'd6});
    n_checks++;
    if (wr_log.size() !== exp_q.size()) begin
      n_errors++; $display("FAIL single_writes got %0d want %0d", wr_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < NC; i++) begin
        n_checks++;
        if (wr_log[i] !== exp_q[i]) begin n_errors++; $display("FAIL single_wr[%0d] got %h want %h", i, wr_log[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_zero_iter();
    run(8'd0, 1'b0, lat);
    n_checks++;
    if (lat !== 1) begin n_errors++; $display("FAIL zero_latency got %0d want 1", lat); end
    n_checks++;
    if ({busy_at_done, busy_after, final_at_done} !== 3'b100) begin
      n_errors++; $display("FAIL zero_busy_final got %b want 100", {busy_at_done, busy_after, final_at_done});
    end
    n_checks++;
    if (rd_log.size() !== 0 || wr_log.size() !== 0) begin
      n_errors++; $display("FAIL zero_traffic got rd=%0d wr=%0d want 0 0", rd_log.size(), wr_log.size());
    end
  endtask

  task automatic test_multi_iter();
    fill_y(3);
    run(8'd3, 1'b0, lat);
    n_checks++;
    if (lat !== 2305) begin n_errors++; $display("FAIL multi_latency got %0d want 2305", lat); end
    n_checks++;
    if (final_at_done !== 1'b1) begin n_errors++; $display("FAIL multi_final got %b want 1", final_at_done); end
    exp_q.delete();
    for (int it = 0; it < 3; it++)
      for (int i = 0; i < NC; i++) exp_q.push_back({(it != 1), 6'(i), 9'(6 << it)});
    n_checks++;
    if (wr_log.size() !== 192) begin
      n_errors++; $display("FAIL multi_writes got %0d want 192", wr_log.size());
    end else begin
      for (int i = 0; i < 192; i++) begin
        n_checks++;
        if (wr_log[i] !== exp_q[i]) begin n_errors++; $display("FAIL multi_wr[%0d] got %h want %h", i, wr_log[i], exp_q[i]); end
      end
    end
    n_checks++;
    if (rd_log.size() !== 1452) begin
      n_errors++; $display("FAIL multi_reads got %0d want 1452", rd_log.size());
    end else begin
      for (int i = 0; i < 1452; i++) begin
        n_checks++;
        if (rd_log[i][6] !== ((i / 484) == 1)) begin
          n_errors++; $display("FAIL multi_rd_bank[%0d] got %b want %b", i, rd_log[i][6], ((i / 484) == 1));
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [71:0] ea;
    ea = '0; ea[39:32] = 8'd2;
    fill_y(3);
    run(8'd1, 1'b1, lat);
    n_checks++;
    if (lat !== 769) begin n_errors++; $display("FAIL ignore_latency got %0d want 769", lat); end
    n_checks++;
    if (bus.dp_a !== ea) begin n_errors++; $display("FAIL ignore_dp_a got %h want %h", bus.dp_a, ea); end
    repeat (20) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || wr_log.size() !== 64) begin
      n_errors++; $display("FAIL ignore_restart got busy=%b wr=%0d want 0 64", bus.busy, wr_log.size());
    end
  endtask

  task automatic test_boundary();
    logic [80:0] ey0, ey63;
    logic [71:0] eu0;
    int nr;
    int nc;
    for (int k = 0; k < 9; k++) begin
      cfg_write(5'(k), 8'(ta[k]));
      cfg_write(5'(k + 9), 8'(tb[k]));
    end
    cfg_write(5'd18, 8'(ti));
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        y_init[r*8+c] = r * 8 + c - 20;
        u_init[r*8+c] = (r * 3 + c * 5) % 17 - 8;
        y_mem[r*8+c] = 9'(y_init[r*8+c]);
        u_mem[r*8+c] = 8'(u_init[r*8+c]);
      end
    ey0 = '0; eu0 = '0; ey63 = '0;
    for (int k = 0; k < 9; k++) begin
      nr = k / 3 - 1; nc = k % 3 - 1;
      if (nr >= 0 && nc >= 0) begin
        ey0[9*k +: 9] = 9'(y_init[nr*8+nc]);
        eu0[8*k +: 8] = 8'(u_init[nr*8+nc]);
      end
      if (nr <= 0 && nc <= 0) ey63[9*k +: 9] = 9'(y_init[(7+nr)*8+7+nc]);
    end
    run(8'd1, 1'b0, lat);
    n_checks++;
    if (en0 !== 9'b110110000) begin n_errors++; $display("FAIL bnd_en_cell0 got %b want 110110000", en0); end
    n_checks++;
    if (en63 !== 9'b000011011) begin n_errors++; $display("FAIL bnd_en_cell63 got %b want 000011011", en63); end
    n_checks++;
    if (snap_y0 !== ey0 || snap_u0 !== eu0) begin
      n_errors++; $display("FAIL bnd_dp_cell0 got y=%h u=%h want y=%h u=%h", snap_y0, snap_u0, ey0, eu0);
    end
    n_checks++;
    if (snap_y63 !== ey63) begin n_errors++; $display("FAIL bnd_dp_cell63 got %h want %h", snap_y63, ey63); end
    n_checks++;
    if (rd_log.size() !== 484) begin
      n_errors++; $display("FAIL bnd_reads got %0d want 484", rd_log.size());
    end else if ({rd_log[0], rd_log[1], rd_log[2], rd_log[3]} !== {7'd0, 7'd1, 7'd8, 7'd9}) begin
      n_errors++; $display("FAIL bnd_rd_addr got %0d %0d %0d %0d want 0 1 8 9", rd_log[0], rd_log[1], rd_log[2], rd_log[3]);
    end
    exp_q.delete();
    for (int i = 0; i < NC; i++) exp_q.push_back({1'b1, 6'(i), 9'(ref_cell(i / 8, i % 8))});
    n_checks++;
    if (wr_log.size() !== 64) begin
      n_errors++; $display("FAIL bnd_writes got %0d want 64", wr_log.size());
    end else begin
      for (int i = 0; i < NC; i++) begin
        n_checks++;
        if (wr_log[i] !== exp_q[i]) begin n_errors++; $display("FAIL bnd_wr[%0d] got %h want %h", i, wr_log[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    fill_y(3);
    @(negedge clk);
    bus.start = 1'b1; bus.iter_count = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.y_we, bus.mem_rd_en} !== 3'b000 || bus.dp_a !== '0 || bus.dbg_state !== 3'd0) begin
      n_errors++; $display("FAIL midrst_clear got flags=%b dp_a=%h st=%0d want 000 0 0",
                           {bus.busy, bus.y_we, bus.mem_rd_en}, bus.dp_a, bus.dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cfg_write(5'd4, 8'd2);
    fill_y(3);
    run(8'd1, 1'b0, lat);
    n_checks++;
    if (lat !== 769) begin n_errors++; $display("FAIL midrst_latency got %0d want 769", lat); end
    n_checks++;
    if (wr_log.size() !== 64) begin
      n_errors++; $display("FAIL midrst_writes got %0d want 64", wr_log.size());
    end else begin
      for (int i = 0; i < NC; i++) begin
        n_checks++;
        if (wr_log[i] !== {1'b1, 6'(i), 9'd6}) begin n_errors++; $display("FAIL midrst_wr[%0d] got %h want %h", i, wr_log[i], {1'b1, 6'(i), 9'd6}); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.start = 1'b0; bus.iter_count = '0;
    for (int i = 0; i < 128; i++) y_mem[i] = '0;
    for (int i = 0; i < 64; i++) u_mem[i] = '0;
    test_reset();
    test_single_iter();
    test_zero_iter();
    test_multi_iter();
    test_busy_ignore();
    test_boundary();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
